// File: rtl/delay_len_sched_pkg.sv
// Shared encodings and default settings for the variable-delay length scheduler.
package delay_len_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_BND = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  localparam int DEF_SR_TARGET      = 0;
  localparam int DEF_SR_STEP        = 1;
  localparam int DEF_SR_MAXSPP      = 2;
  localparam int DEF_DEFAULT_MAXSPP = 256;

endpackage

// File: rtl/delay_len_sched_regs.sv
// Settings-bus decoder holding target, max-step and max_spp; writes visible next cycle.
// Clear zeroes only the target; reset and clear both win over a same-cycle write.
module delay_len_sched_regs
  import delay_len_sched_pkg::*;
#(
  parameter int MAX_LEN_LOG2   = 10,
  parameter int SR_AWIDTH      = 8,
  parameter int SR_DWIDTH      = 32,
  parameter int SR_TARGET      = DEF_SR_TARGET,
  parameter int SR_STEP        = DEF_SR_STEP,
  parameter int SR_MAXSPP      = DEF_SR_MAXSPP,
  parameter int DEFAULT_MAXSPP = DEF_DEFAULT_MAXSPP
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    set_stb,
  input  logic [SR_AWIDTH-1:0]    set_addr,
  input  logic [SR_DWIDTH-1:0]    set_data,
  output logic [MAX_LEN_LOG2-1:0] target,
  output logic [MAX_LEN_LOG2-1:0] step,
  output logic [MAX_LEN_LOG2-1:0] max_spp
);

  logic [MAX_LEN_LOG2-1:0] target_q, target_d;
  logic [MAX_LEN_LOG2-1:0] step_q, step_d;
  logic [MAX_LEN_LOG2-1:0] max_spp_q, max_spp_d;
  logic [MAX_LEN_LOG2-1:0] wr_val;
  logic                    unused_data_hi;

  assign wr_val         = set_data[MAX_LEN_LOG2-1:0];
  assign unused_data_hi = ^set_data[SR_DWIDTH-1:MAX_LEN_LOG2];

  always_comb begin
    target_d  = target_q;
    step_d    = step_q;
    max_spp_d = max_spp_q;
    if (set_stb) begin
      if (set_addr == SR_AWIDTH'(SR_TARGET)) target_d  = wr_val;
      if (set_addr == SR_AWIDTH'(SR_STEP))   step_d    = wr_val;
      if (set_addr == SR_AWIDTH'(SR_MAXSPP)) max_spp_d = wr_val;
    end
    if (clear) target_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      target_q  <= '0;
      step_q    <= '0;
      max_spp_q <= MAX_LEN_LOG2'(DEFAULT_MAXSPP);
    end else begin
      target_q  <= target_d;
      step_q    <= step_d;
      max_spp_q <= max_spp_d;
    end
  end

  assign target  = target_q;
  assign step    = step_q;
  assign max_spp = max_spp_q;

endmodule

// File: rtl/delay_len_sched.sv
// Slews the delay-line length toward a software target, one bounded step per output
// packet boundary; target write to busy is two cycles, len moves only on a tlast beat.
module delay_len_sched
  import delay_len_sched_pkg::*;
#(
  parameter int MAX_LEN_LOG2   = 10,
  parameter int SR_AWIDTH      = 8,
  parameter int SR_DWIDTH      = 32,
  parameter int SR_TARGET      = DEF_SR_TARGET,
  parameter int SR_STEP        = DEF_SR_STEP,
  parameter int SR_MAXSPP      = DEF_SR_MAXSPP,
  parameter int DEFAULT_MAXSPP = DEF_DEFAULT_MAXSPP
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    set_stb,
  input  logic [SR_AWIDTH-1:0]    set_addr,
  input  logic [SR_DWIDTH-1:0]    set_data,
  input  logic                    mon_tvalid,
  input  logic                    mon_tready,
  input  logic                    mon_tlast,
  output logic [MAX_LEN_LOG2-1:0] len,
  output logic [MAX_LEN_LOG2-1:0] max_spp,
  output logic                    busy,
  output logic                    done_stb
);

  logic [MAX_LEN_LOG2-1:0] target, step;
  logic [MAX_LEN_LOG2-1:0] len_q, len_d;
  logic [MAX_LEN_LOG2-1:0] delta, applied, next_len;
  logic                    going_up, bnd;
  state_t                  state_q, state_d;

  delay_len_sched_regs #(
    .MAX_LEN_LOG2  (MAX_LEN_LOG2),
    .SR_AWIDTH     (SR_AWIDTH),
    .SR_DWIDTH     (SR_DWIDTH),
    .SR_TARGET     (SR_TARGET),
    .SR_STEP       (SR_STEP),
    .SR_MAXSPP     (SR_MAXSPP),
    .DEFAULT_MAXSPP(DEFAULT_MAXSPP)
  ) u_regs (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .set_stb (set_stb),
    .set_addr(set_addr),
    .set_data(set_data),
    .target  (target),
    .step    (step),
    .max_spp (max_spp)
  );

  assign bnd = mon_tvalid & mon_tready & mon_tlast;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    going_up = target > len_q;
    delta    = going_up ? (target - len_q) : (len_q - target);
    // Clamping the step to the remaining distance keeps len from overshooting or wrapping.
    applied  = ((step == '0) || (step >= delta)) ? delta : step;
    next_len = going_up ? (len_q + applied) : (len_q - applied);

    case (state_q)
      ST_IDLE: begin
        if (len_q != target) state_d = ST_WAIT_BND;
      end
      ST_WAIT_BND: begin
        if (len_q == target) begin
          state_d = ST_DONE;
        end else if (bnd) begin
          len_d = next_len;
          if (next_len == target) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (clear) begin
      len_d   = '0;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_q   <= '0;
      state_q <= ST_IDLE;
    end else begin
      len_q   <= len_d;
      state_q <= state_d;
    end
  end

  assign len      = len_q;
  assign busy     = (state_q == ST_WAIT_BND);
  assign done_stb = (state_q == ST_DONE);

endmodule

// File: doc/delay_len_sched.md
Name: delay_len_sched

Overview:
Runtime controller for the packet-stream variable delay line.
- Owns the delay line's `len` and `max_spp` inputs, loaded from the settings bus.
- Slews `len` toward a software-written target, one bounded step per output packet boundary. Delay changes never land mid-packet and never jump arbitrarily far.
- Watches the delay line's output handshake to find packet boundaries.
- Reports busy/done status to software.

Parameters:
- MAX_LEN_LOG2, 10, width of `len`, `max_spp` and step values.
- SR_AWIDTH, 8, settings bus address width.
- SR_DWIDTH, 32, settings bus data width.
- SR_TARGET, 0, address of the target-delay register.
- SR_STEP, 1, address of the max-step register (0 = unlimited).
- SR_MAXSPP, 2, address of the `max_spp` register.
- DEFAULT_MAXSPP, 256, reset value of `max_spp`.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous soft clear
- set_stb  in  1  settings write strobe
- set_addr  in  SR_AWIDTH  settings address
- set_data  in  SR_DWIDTH  settings data; low MAX_LEN_LOG2 bits used
- mon_tvalid  in  1  delay line `o_tvalid`
- mon_tready  in  1  delay line `o_tready`
- mon_tlast  in  1  delay line `o_tlast`
- len  out  MAX_LEN_LOG2  delay length to the delay line
- max_spp  out  MAX_LEN_LOG2  max samples-per-packet to the delay line
- busy  out  1  high while `len` != target
- done_stb  out  1  one-cycle pulse when `len` reaches target

Behaviour:
- Reset: all outputs and registers return to defaults.
  - `len`=0, target=0, step=0, `max_spp`=DEFAULT_MAXSPP, `busy`=0, `done_stb`=0, state=IDLE.
- `clear`: `len`=0, target=0, state=IDLE, `busy`=0. Step and `max_spp` are retained.
- Register writes:
  - A write takes effect when `set_stb` is high and `set_addr` matches; the value is visible the next cycle.
  - Unmatched addresses are ignored.
  - Data is truncated to MAX_LEN_LOG2 bits.
- Boundary beat = `mon_tvalid` & `mon_tready` & `mon_tlast`.
- States:
  - IDLE:
    - `len`==target → remain in IDLE.
    - Otherwise → go to WAIT_BND with `busy`=1 the following cycle.
  - WAIT_BND: on a boundary beat, update `len` on the same clock edge.
    - Step size: delta = |target−len|; applied step = delta if step==0 or step≥delta, otherwise step.
    - Direction: `len` moves toward target by the applied step.
    - Next state = DONE if the new `len`==target, otherwise stay in WAIT_BND.
  - DONE: `done_stb`=1 for exactly one cycle, `busy`=0, then go to IDLE.
- Arithmetic: unsigned compare; `len` never overshoots target and never wraps.
- Target rewritten mid-slew:
  - The next boundary step uses the new target.
  - A direction reversal is allowed.
  - If the new target equals the current `len`, go to DONE on the next cycle without waiting for a boundary.
- Target write and boundary beat in the same cycle: the step uses the old target; the new target applies from the next boundary.
- Step write mid-slew: applies to the next update.
- Boundary beats while IDLE: ignored.
- `max_spp` register drives the `max_spp` output directly; no packet alignment.
- Latency: a target write reaches `busy`=1 two cycles later. `len` changes only on the edge of a boundary beat.
- `reset` and `clear` take priority over settings writes in the same cycle.

Decomposition:
- Shared package holds:
  - state encodings IDLE/WAIT_BND/DONE;
  - default settings addresses SR_TARGET/SR_STEP/SR_MAXSPP;
  - DEFAULT_MAXSPP.
- One sub-module: delay_len_sched_regs, the settings decoder holding the target/step/`max_spp` registers.
- The slew FSM and step arithmetic stay in the top module.

Test Plan:
- Reset, no writes → `len`=0, `max_spp`=256, `busy`=0, no `done_stb`.
- Step=0, write target=100, then one boundary beat → `len` 0→100 on that edge, `done_stb` pulses once, `busy` falls.
- Step=16, target=40 from `len`=0, three boundary beats → `len` goes 16, 32, 40; `busy` high until the third; non-tlast beats cause no change.
- At `len`=32, target=40 is overwritten with target=8 → next boundary gives `len`=16, then 8; done after two boundaries.
- Target write coincident with a boundary (`len`=10, old target=20, new target=0, step=0) → `len`=20 then DONE; next cycle IDLE sees target 0 → WAIT_BND; next boundary gives `len`=0.
- `clear` mid-slew (`len`=48) → `len`=0, `busy`=0; step and `max_spp` unchanged; writing SR_MAXSPP=64 → `max_spp`=64 the next cycle.
